// File: rtl/sample_scheduler.sv
// Purpose: sample-rate strobe generator; one 16-clock SPI ADC read and one DAC update per strobe.
// Latency: tick in cycle T -> cs low and dac update at T+1, adc_valid at T+1+33*SCLK_HALF.
// Backpressure: one-deep DAC holding register; dac_in_ready low while it is full, cleared by each tick.
//
// Ports:
//   sysclk, reset                - system clock, asynchronous active-high reset
//   enable                       - level; while low the period counter is held at 0
//   dac_in/dac_in_valid/ready    - modulator write into the DAC holding register
//   dac                          - registered DAC pins, updated on each tick
//   cs, sclk, sdo                - ADC serial port (cs active low, sclk idles high, sdo MSB first)
//   adc_data, adc_valid          - last captured sample and its one-cycle update strobe
//   sample_tick                  - one-cycle strobe per sample period
//   overrun, underrun, frame_err - one-cycle status pulses
module sample_scheduler #(
    parameter int         SAMPLE_DIV = 250,
    parameter int         SCLK_HALF  = 2,
    parameter logic [7:0] DAC_IDLE   = 8'h80
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  dac_in,
    input  logic        dac_in_valid,
    output logic        dac_in_ready,
    output logic [7:0]  dac,
    output logic        cs,
    output logic        sclk,
    input  logic        sdo,
    output logic [11:0] adc_data,
    output logic        adc_valid,
    output logic        sample_tick,
    output logic        overrun,
    output logic        underrun,
    output logic        frame_err
);

    localparam int CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SAMPLE_DIV - 2);

    localparam int PH_W = $clog2(2 * SCLK_HALF) + 1;
    localparam logic [PH_W-1:0] HALF_LAST = PH_W'(SCLK_HALF - 1);
    localparam logic [PH_W-1:0] PER_LAST  = PH_W'(2 * SCLK_HALF - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

    logic [CNT_W-1:0] count;
    logic             full;
    logic [7:0]       hold;
    state_t           state;
    logic [PH_W-1:0]  ph;
    logic [3:0]       bit_cnt;
    logic [15:0]      shift;

    assign dac_in_ready = ~full;

    // Period counter. The tick is registered one count early so that it is
    // high exactly while the count sits at SAMPLE_DIV-1.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else begin
            count       <= (count == CNT_LAST) ? '0 : count + CNT_W'(1);
            sample_tick <= (count == CNT_PRE);
        end
    end

    // DAC holding register. A write can only land while empty, so a tick that
    // drains the register never collides with a write in the same cycle; a
    // write coincident with an empty-register tick is kept for the next tick.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            full     <= 1'b0;
            hold     <= '0;
            dac      <= DAC_IDLE;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (sample_tick) begin
                if (full) begin
                    dac  <= hold;
                    full <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (dac_in_valid && !full) begin
                hold <= dac_in;
                full <= 1'b1;
            end
        end
    end

    // SPI read FSM. ph counts cycles within SETUP, within one sclk period in
    // SHIFT, and within QUIET.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ph        <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            cs        <= 1'b1;
            sclk      <= 1'b1;
            adc_data  <= '0;
            adc_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            adc_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    cs   <= 1'b1;
                    sclk <= 1'b1;
                    if (sample_tick) begin
                        state <= SETUP;
                        cs    <= 1'b0;
                        ph    <= '0;
                    end
                end
                SETUP: begin
                    if (ph == HALF_LAST) begin
                        state   <= SHIFT;
                        sclk    <= 1'b0;
                        ph      <= '0;
                        bit_cnt <= '0;
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                SHIFT: begin
                    // sdo is captured on the edge that drives sclk high.
                    if (ph == HALF_LAST) begin
                        sclk  <= 1'b1;
                        shift <= {shift[14:0], sdo};
                    end
                    if (ph == PER_LAST) begin
                        ph <= '0;
                        if (bit_cnt == 4'd15) begin
                            state     <= QUIET;
                            cs        <= 1'b1;
                            adc_data  <= shift[11:0];
                            adc_valid <= 1'b1;
                            frame_err <= |shift[15:12];
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                QUIET: begin
                    if (ph == PER_LAST) begin
                        state <= IDLE;
                        ph    <= '0;
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Purpose: directed bench for sample_scheduler at default and fast (SAMPLE_DIV=40) rates.
// Latency: checks strobe, SPI and DAC timing relative to each observed tick.
// Backpressure: exercises the one-deep DAC register (ready low until tick, write on tick cycle).
module tb_sample_scheduler;

    logic        sysclk = 1'b0;
    logic        reset;

    // default-rate instance
    logic        enable_a, valid_a, ready_a, cs_a, sclk_a, sdo_a;
    logic [7:0]  din_a, dac_a;
    logic [11:0] adc_a;
    logic        aval_a, tick_a, ovr_a, und_a, ferr_a;
    logic [15:0] word_a = 16'h0ABC;
    logic [4:0]  nbit_a = '0;

    // fast-rate instance
    logic        enable_b, valid_b, ready_b, cs_b, sclk_b, sdo_b;
    logic [7:0]  din_b, dac_b;
    logic [11:0] adc_b;
    logic        aval_b, tick_b, ovr_b, und_b, ferr_b;
    logic [15:0] word_b = 16'h0123;
    logic [4:0]  nbit_b = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sysclk = ~sysclk;

    sample_scheduler u_dut (
        .sysclk(sysclk), .reset(reset), .enable(enable_a),
        .dac_in(din_a), .dac_in_valid(valid_a), .dac_in_ready(ready_a),
        .dac(dac_a), .cs(cs_a), .sclk(sclk_a), .sdo(sdo_a),
        .adc_data(adc_a), .adc_valid(aval_a), .sample_tick(tick_a),
        .overrun(ovr_a), .underrun(und_a), .frame_err(ferr_a)
    );

    sample_scheduler #(.SAMPLE_DIV(40), .SCLK_HALF(2), .DAC_IDLE(8'h80)) u_dut_fast (
        .sysclk(sysclk), .reset(reset), .enable(enable_b),
        .dac_in(din_b), .dac_in_valid(valid_b), .dac_in_ready(ready_b),
        .dac(dac_b), .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b),
        .adc_data(adc_b), .adc_valid(aval_b), .sample_tick(tick_b),
        .overrun(ovr_b), .underrun(und_b), .frame_err(ferr_b)
    );

    // ADC models: bit 15 presented when cs falls, next bit after each sclk rise.
    always @(posedge sclk_a or posedge cs_a) begin
        if (cs_a) nbit_a <= '0;
        else      nbit_a <= nbit_a + 5'd1;
    end
    assign sdo_a = (cs_a || nbit_a[4]) ? 1'b0 : word_a[4'd15 - nbit_a[3:0]];

    always @(posedge sclk_b or posedge cs_b) begin
        if (cs_b) nbit_b <= '0;
        else      nbit_b <= nbit_b + 5'd1;
    end
    assign sdo_b = (cs_b || nbit_b[4]) ? 1'b0 : word_b[4'd15 - nbit_b[3:0]];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic wait_tick_a(input int budget);
        int  n;
        logic found;
        n = 0;
        found = 1'b0;
        while (n < budget && !found) begin
            step();
            n++;
            if (tick_a) found = 1'b1;
        end
        check("tick_a_found", 32'(found), 1);
    endtask

    initial begin : main
        int first_fall, falls, cs_rise, val_k, tick_k, nval, first_v, second_v, idx;
        logic prev_sclk, rdy_bad, found;
        logic [11:0] cap_data;
        logic cap_ferr;

        reset = 1'b1;
        enable_a = 1'b0; valid_a = 1'b0; din_a = '0;
        enable_b = 1'b0; valid_b = 1'b0; din_b = '0;
        repeat (3) step();

        check("rst_cs",        32'(cs_a),    1);
        check("rst_sclk",      32'(sclk_a),  1);
        check("rst_dac",       32'(dac_a),   'h80);
        check("rst_adc_data",  32'(adc_a),   0);
        check("rst_adc_valid", 32'(aval_a),  0);
        check("rst_tick",      32'(tick_a),  0);
        check("rst_overrun",   32'(ovr_a),   0);
        check("rst_underrun",  32'(und_a),   0);
        check("rst_frame_err", 32'(ferr_a),  0);
        check("rst_ready",     32'(ready_a), 1);

        reset = 1'b0;
        step();
        enable_a = 1'b1;

        // Tick 1 with empty holding register.
        wait_tick_a(300);
        step();
        check("t1_underrun", 32'(und_a), 1);
        check("t1_dac_idle", 32'(dac_a), 'h80);
        check("t1_cs_low",   32'(cs_a),  0);

        din_a = 8'h3C; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check("wr1_ready_low", 32'(ready_a), 0);

        // Watch the tick-1 transaction through to tick 2 (now at T1+2).
        first_fall = 0; falls = 0; cs_rise = 0; val_k = 0; tick_k = 0;
        prev_sclk = sclk_a; rdy_bad = 1'b0; cap_data = '0; cap_ferr = 1'b0;
        for (int k = 3; k <= 300 && tick_k == 0; k++) begin
            step();
            if (prev_sclk && !sclk_a) begin
                falls++;
                if (first_fall == 0) first_fall = k;
            end
            prev_sclk = sclk_a;
            if (cs_a && cs_rise == 0) cs_rise = k;
            if (aval_a && val_k == 0) begin
                val_k = k; cap_data = adc_a; cap_ferr = ferr_a;
            end
            if (ready_a) rdy_bad = 1'b1;
            if (tick_a) tick_k = k;
        end
        check("first_sclk_fall", 32'(first_fall), 3);
        check("sclk_falls",      32'(falls),      16);
        check("cs_rise",         32'(cs_rise),    67);
        check("adc_valid_time",  32'(val_k),      67);
        check("adc_data_abc",    32'(cap_data),   'hABC);
        check("frame_err_clear", 32'(cap_ferr),   0);
        check("tick_period",     32'(tick_k),     250);
        check("ready_held_low1", 32'(rdy_bad),    0);

        step();
        check("t2_dac",      32'(dac_a),   'h3C);
        check("t2_underrun", 32'(und_a),   0);
        check("t2_ready",    32'(ready_a), 1);

        din_a = 8'hC3; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        rdy_bad = 1'b0; tick_k = 0;
        for (int k = 3; k <= 300 && tick_k == 0; k++) begin
            step();
            if (ready_a) rdy_bad = 1'b1;
            if (tick_a) tick_k = k;
        end
        check("tick_period2",    32'(tick_k),  250);
        check("ready_held_low2", 32'(rdy_bad), 0);
        step();
        check("t3_dac",      32'(dac_a), 'hC3);
        check("t3_underrun", 32'(und_a), 0);

        // Tick 4: write in the tick cycle itself, ADC returns all ones.
        repeat (80) step();
        word_a = 16'hFFFF;
        wait_tick_a(300);
        din_a = 8'h5A; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check("t4_underrun", 32'(und_a),   1);
        check("t4_dac_hold", 32'(dac_a),   'hC3);
        check("t4_stored",   32'(ready_a), 0);
        val_k = 0;
        for (int k = 2; k <= 100 && val_k == 0; k++) begin
            step();
            if (aval_a) begin
                val_k = k; cap_data = adc_a; cap_ferr = ferr_a;
            end
        end
        check("t4_valid_time", 32'(val_k),    67);
        check("t4_adc_fff",    32'(cap_data), 'hFFF);
        check("t4_frame_err",  32'(cap_ferr), 1);

        wait_tick_a(300);
        step();
        check("t5_dac",      32'(dac_a), 'h5A);
        check("t5_underrun", 32'(und_a), 0);
        word_a = 16'h0ABC;

        // Asynchronous reset at T5+20, between clock edges.
        repeat (19) step();
        check("pre_reset_cs_low", 32'(cs_a), 0);
        @(posedge sysclk);
        #2 reset = 1'b1;
        #1;
        check("arst_cs",    32'(cs_a),    1);
        check("arst_sclk",  32'(sclk_a),  1);
        check("arst_dac",   32'(dac_a),   'h80);
        check("arst_ready", 32'(ready_a), 1);
        step();
        reset = 1'b0;
        tick_k = 0; val_k = 0;
        for (int k = 1; k <= 400 && val_k == 0; k++) begin
            step();
            if (tick_a && tick_k == 0) tick_k = k;
            if (aval_a) val_k = k;
        end
        check("post_reset_valid_gap", 32'(val_k - tick_k), 67);
        enable_a = 1'b0;

        // Fast instance: tick every 40 cycles, transaction needs 71.
        din_b = 8'h10; valid_b = 1'b1;
        step();
        check("b_ready_low", 32'(ready_b), 0);
        enable_b = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (tick_b) found = 1'b1;
        end
        check("b_tick_found", 32'(found), 1);
        nval = 0; first_v = 0; second_v = 0;
        for (int k = 1; k <= 199; k++) begin
            step();
            if (k % 40 == 1) begin
                idx = k / 40;
                check("b_dac",     32'(dac_b), 32'('h10 + idx));
                check("b_overrun", 32'(ovr_b), 32'(idx % 2));
                din_b = 8'('h10 + idx + 1);
            end
            if (aval_b) begin
                nval++;
                if (first_v == 0) first_v = k;
                else second_v = k;
                check("b_adc_data", 32'(adc_b), 'h123);
            end
        end
        check("b_valid_count",   32'(nval),               2);
        check("b_valid_first",   32'(first_v),            67);
        check("b_valid_spacing", 32'(second_v - first_v), 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
